// File: rtl/knight_pkg.sv
// Shared constants and types for the knight flasher trail display.
package knight_pkg;
  localparam int LEDS   = 8;
  localparam int BW_DEF = 4;
  localparam int MAX    = (2 ** BW_DEF) - 1;

  typedef logic [BW_DEF-1:0] bright_t;
endpackage

// File: rtl/knight_trail_if.sv
// Strobe/position input and LED drive bus of the trail display stage.
interface knight_trail_if;
  logic                         adv;
  logic [knight_pkg::LEDS-1:0]  pos;
  logic [knight_pkg::LEDS-1:0]  led;

  modport master (output adv, pos, input  led);
  modport slave  (input  adv, pos, output led);
endinterface

// File: rtl/knight_trail_cell.sv
// One LED of the trail: brightness register with load/decay/saturate and PWM compare flop.
module trail_cell #(
  parameter int BW    = knight_pkg::BW_DEF,
  parameter int DECAY = 5
) (
  input  logic          ck,
  input  logic          res,
  input  logic          adv,
  input  logic          hit,
  input  logic [BW-1:0] pwm_ct,
  output logic          led
);
  localparam logic [BW-1:0] FULL = {BW{1'b1}};
  localparam logic [BW-1:0] STEP = BW'(DECAY);

  logic [BW-1:0] bright;
  logic [BW-1:0] bright_nxt;

  always_comb begin
    // NOTE: default assignment first keeps every path assigned, so no latch is inferred.
    bright_nxt = bright;
    if (adv) begin
      if (hit)                bright_nxt = FULL;
      else if (bright > STEP) bright_nxt = bright - STEP;
      else                    bright_nxt = '0;
    end
  end

  // NOTE: the brightness store is reset, because an unknown level would light the board randomly.
  always_ff @(posedge ck) begin
    if (res) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      bright <= '0;
      led    <= 1'b0;
    end else begin
      bright <= bright_nxt;
      led    <= (bright > pwm_ct);
    end
  end
endmodule

// File: rtl/knight_trail.sv
// Trail display top: shared PWM counter feeding eight brightness cells.
module knight_trail
  import knight_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int DECAY = 5
) (
  input  logic           ck,
  input  logic           res,
  knight_trail_if.slave  bus
);
  // Counter stops one short of all-ones so a full-brightness LED is never low.
  localparam logic [BW-1:0] LAST = BW'((2 ** BW) - 2);

  logic [BW-1:0]   pwm_ct;
  logic [LEDS-1:0] led_w;

  always_ff @(posedge ck) begin
    if (res)                 pwm_ct <= '0;
    else if (pwm_ct == LAST) pwm_ct <= '0;
    else                     pwm_ct <= pwm_ct + 1'b1;
  end

  for (genvar i = 0; i < LEDS; i++) begin : g_cell
    trail_cell #(
      .BW    (BW),
      .DECAY (DECAY)
    ) u_cell (
      .ck     (ck),
      .res    (res),
      .adv    (bus.adv),
      .hit    (bus.pos[i]),
      .pwm_ct (pwm_ct),
      .led    (led_w[i])
    );
  end

  assign bus.led = led_w;
endmodule

// File: doc/knight_trail.md
# knight_trail

Downstream display stage for the knight flasher. Takes the flasher's 8-bit one-hot position and an advance strobe, and keeps a per-LED brightness level. The lit position jumps to full brightness and previously lit LEDs fade by a fixed step on each advance, which gives the sweeping light a decaying tail. Brightness is rendered with a shared free-running PWM counter, and the resulting LED drive is the block's registered output to the board.

## Interface
- `BW`, default 4: brightness and PWM counter width in bits; `MAX = 2**BW - 1`.
- `DECAY`, default 5: amount subtracted from a non-lit LED's brightness per advance; legal range 1..MAX.
- `ck`  in  1: clock.
- `res`  in  1: reset. One clock; reset is synchronous and active-high.
- `adv`  in  1: single-cycle strobe; the flasher position has advanced and `pos` is valid.
- `pos`  in  8: flasher position, nominally one-hot; only sampled when `adv`=1.
- `led`  out  8: PWM LED drive, registered.

## Operation
- **State.** Each LED i has `bright[i]`, BW bits wide. One shared counter `pwm_ct`, BW bits wide.
- **Brightness update, when `adv`=1.** For each i:
  - if `pos[i]`=1: `bright[i]` becomes MAX;
  - else if `bright[i]` > DECAY: `bright[i]` becomes `bright[i]` - DECAY;
  - else: `bright[i]` becomes 0 (saturating, never wraps).
- **Brightness hold, when `adv`=0.** All `bright[i]` hold their values.
- **`pos` encodings.**
  - `pos` is not required to be one-hot. Every set bit loads MAX.
  - `pos`=0 decays all LEDs.
  - Repeated identical `pos` values (the flasher's end-of-sweep double step, e.g. `8'h80` twice) keep that LED at MAX.
- **PWM counter.**
  - `pwm_ct` counts 0..MAX-1 and wraps to 0; the period is MAX cycles (15 at default).
  - It runs continuously and is independent of `adv`.
- **PWM output.** `led[i]` is registered as (`bright[i]` > `pwm_ct`).
  - `bright`=MAX gives always on; `bright`=0 gives always off.
  - Brightness b gives exactly b high cycles per period.
- **Sequential events.** Only one brightness state is updated per cycle, so no multi-event arbitration is needed.
  - `adv` coincident with the `pwm_ct` wrap: the brightness update and the wrap both take effect normally.
  - A brightness change mid-period takes effect on the next compare; no period alignment is applied.
- **Reset.** `res`=1 at a clock edge sets all `bright`=0, `pwm_ct`=0 and `led`=8'h00. Reset overrides a coincident `adv`. A reset mid-period simply restarts the period.

## Timing
- `adv` sampled at edge N updates `bright` at edge N; `led` reflects the new value from edge N+1 (1-cycle output latency after the state update).
- `pwm_ct` advances every cycle once `res` is deasserted; the first post-reset cycle compares against `pwm_ct`=0.
- No back-pressure and no handshake: `adv` is a fire-and-forget strobe. Back-to-back `adv` strobes on consecutive cycles are legal; each applies one decay step.
- All outputs are registered; there is no combinational path from `pos` or `adv` to `led`.

## Structure
- Shared package `knight_pkg`:
  - `LEDS` = 8;
  - the default `BW`;
  - a brightness `typedef` of BW bits;
  - the `MAX` constant.
- Sub-module `trail_cell`, instantiated 8 times. Each instance holds one `bright` register with its load/decay/saturate logic and the `led` compare flop.
- Top level: `pwm_ct`, the fan-out of `adv`, `pos[i]` and `pwm_ct` to the cells, and the `led` bus assembly.

## Test plan
1. **Reset.** `res`=1 for 2 cycles with `adv`=1, `pos`=8'hFF -> `led`=8'h00, all `bright`=0, `pwm_ct`=0 after release.
2. **Single load.** `adv` pulse with `pos`=8'h01 -> `led[0]` high for 15 of every 15 cycles; `led[7:1]` stay 0.
3. **Trail.** Pulse `pos`=8'h01, then pulse `pos`=8'h02 -> `bright[0]`=10, so `led[0]` is high 10 of 15 cycles; `led[1]` is high 15 of 15.
4. **Saturating decay.** From `bright[0]`=15, four pulses with `pos`=8'h00 -> 10, 5, 0, 0; `led[0]` stays low with no underflow.
5. **Multi-hot and end-of-sweep.** `pos`=8'h81 -> `bright[0]` and `bright[7]` = 15. Then two consecutive pulses with `pos`=8'h80 -> `bright[7]` stays 15 and `bright[0]` goes 10, 5.
6. **Mid-operation reset.** `res` asserted at `pwm_ct`=7 while `adv`=1 -> next cycle `led`=0 and `pwm_ct`=0; the full period restarts after release.
